// File: rtl/timer_deadtime_if.sv
// rtl/timer_deadtime_if.sv - system-peripheral bus bundle for timer_deadtime
interface timer_deadtime_if;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;

    modport master (output waddr_i, data_i, sel_i, we_i, raddr_i, rd_i, input data_o);
    modport slave  (input waddr_i, data_i, sel_i, we_i, raddr_i, rd_i, output data_o);
endinterface

// File: rtl/timer_deadtime.sv
// rtl/timer_deadtime.sv - complementary PWM stage with programmable dead time and brake
// Optional brake path enabled by defining DEADTIME_BRAKE_EN.
module timer_deadtime (
    input  logic            clk,
    input  logic            rst_n,
    timer_deadtime_if.slave bus,
    input  logic            pwm_i,
    input  logic            brk_i,
    output logic            pwm_hi_o,
    output logic            pwm_lo_o,
    output logic            irq_brk_o
);
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_CFG  = 8'h04;
    localparam logic [7:0] A_STAT = 8'h08;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_LO   = 3'd1,
        ST_DT_R = 3'd2,
        ST_HI   = 3'd3,
        ST_DT_F = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d, brk_ie_q, brk_ie_d, pol_q, pol_d;
    logic [7:0]  dtr_q, dtr_d, dtf_q, dtf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  swal_q, swal_d;
    logic [15:0] dlv_q, dlv_d;
    logic        pwm_q;
    logic        hi_q, hi_d, lo_q, lo_d;
    logic [31:0] data_q, data_d, rdata;
    logic        brk_flag;

    wire wr_ctrl = bus.we_i && (bus.waddr_i == A_CTRL);
    wire wr_cfg  = bus.we_i && (bus.waddr_i == A_CFG);
    wire unused_bus = &{1'b0, bus.sel_i, bus.data_i[31:16]};

`ifdef DEADTIME_BRAKE_EN
    logic brk_m_q, brk_s_q, brk_flag_q, brk_flag_d, irq_q, irq_d;
    wire  brk_clr = bus.we_i && (bus.waddr_i == A_STAT) && bus.data_i[0];

    // Set dominates clear, so the flag cannot drop while the brake is still held.
    always_comb begin
        brk_flag_d = brk_s_q | (brk_flag_q & ~brk_clr);
        irq_d      = brk_s_q & ~brk_flag_q & brk_ie_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_m_q    <= 1'b0;
            brk_s_q    <= 1'b0;
            brk_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            brk_m_q    <= brk_i;
            brk_s_q    <= brk_m_q;
            brk_flag_q <= brk_flag_d;
            irq_q      <= irq_d;
        end
    end

    assign brk_flag  = brk_flag_q;
    assign irq_brk_o = irq_q;
`else
    wire unused_brk = brk_i;
    assign brk_flag  = 1'b0;
    assign irq_brk_o = 1'b0;
`endif

    always_comb begin
        en_d     = en_q;
        brk_ie_d = brk_ie_q;
        pol_d    = pol_q;
        dtr_d    = dtr_q;
        dtf_d    = dtf_q;
        if (wr_ctrl) begin
            en_d     = bus.data_i[0];
            brk_ie_d = bus.data_i[1];
            pol_d    = bus.data_i[2];
        end
        if (wr_cfg) begin
            dtr_d = bus.data_i[7:0];
            dtf_d = bus.data_i[15:8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swal_d  = swal_q;
        dlv_d   = dlv_q;
        if (!en_q) begin
            state_d = ST_OFF;
            cnt_d   = 8'd0;
            swal_d  = 8'd0;
            dlv_d   = 16'd0;
        end else if (brk_flag) begin
            state_d = ST_OFF;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_LO;
                ST_LO: begin
                    if (pwm_q) begin
                        if (dtr_q == 8'd0) begin
                            state_d = ST_HI;
                            dlv_d   = dlv_q + 16'd1;
                        end else begin
                            state_d = ST_DT_R;
                            cnt_d   = dtr_q;
                        end
                    end
                end
                ST_DT_R: begin
                    if (!pwm_q) begin
                        state_d = ST_LO;
                        if (swal_q != 8'hFF) swal_d = swal_q + 8'd1;
                    end else if (cnt_q == 8'd1) begin
                        state_d = ST_HI;
                        dlv_d   = dlv_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_HI: begin
                    if (!pwm_q) begin
                        if (dtf_q == 8'd0) begin
                            state_d = ST_LO;
                        end else begin
                            state_d = ST_DT_F;
                            cnt_d   = dtf_q;
                        end
                    end
                end
                ST_DT_F: begin
                    // A pulse that returns high inside the gap resumes HI without counting as delivered.
                    if (pwm_q) begin
                        state_d = ST_HI;
                        if (swal_q != 8'hFF) swal_d = swal_q + 8'd1;
                    end else if (cnt_q == 8'd1) begin
                        state_d = ST_LO;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        hi_d = (state_d == ST_HI) ^ pol_q;
        lo_d = (state_d == ST_LO) ^ pol_q;
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.raddr_i)
            A_CTRL:  rdata = {29'd0, pol_q, brk_ie_q, en_q};
            A_CFG:   rdata = {16'd0, dtf_q, dtr_q};
            A_STAT:  rdata = {dlv_q, swal_q, 4'd0, state_q, brk_flag};
            default: rdata = 32'd0;
        endcase
        data_d = bus.rd_i ? rdata : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            en_q     <= 1'b0;
            brk_ie_q <= 1'b0;
            pol_q    <= 1'b0;
            dtr_q    <= 8'd0;
            dtf_q    <= 8'd0;
            cnt_q    <= 8'd0;
            swal_q   <= 8'd0;
            dlv_q    <= 16'd0;
            pwm_q    <= 1'b0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            brk_ie_q <= brk_ie_d;
            pol_q    <= pol_d;
            dtr_q    <= dtr_d;
            dtf_q    <= dtf_d;
            cnt_q    <= cnt_d;
            swal_q   <= swal_d;
            dlv_q    <= dlv_d;
            pwm_q    <= pwm_i;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
        end
    end

    assign pwm_hi_o = hi_q;
    assign pwm_lo_o = lo_q;
    assign bus.data_o = data_q;
endmodule

// File: tb/tb_timer_deadtime.sv
// tb/tb_timer_deadtime.sv - randomized self-checking bench for timer_deadtime
module tb_timer_deadtime;
`ifdef DEADTIME_BRAKE_EN
    localparam bit BRK_ON = 1'b1;
`else
    localparam bit BRK_ON = 1'b0;
`endif
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_CFG  = 8'h04;
    localparam logic [7:0] A_STAT = 8'h08;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_i, brk_i;
    logic pwm_hi_o, pwm_lo_o, irq_brk_o;

    timer_deadtime_if bus_if ();

    timer_deadtime dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .pwm_i    (pwm_i),
        .brk_i    (brk_i),
        .pwm_hi_o (pwm_hi_o),
        .pwm_lo_o (pwm_lo_o),
        .irq_brk_o(irq_brk_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: output side the stage is heading for, and cycles of gap still owed.
    bit m_en, m_ie, m_pol, m_flag, m_b1, m_b2, m_pwm_q;
    bit m_active, m_dir, m_hi, m_lo, m_irq;
    int m_dtr, m_dtf, m_wait, m_swal, m_dlv;
    logic [31:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_pol = 0; m_flag = 0; m_b1 = 0; m_b2 = 0; m_pwm_q = 0;
        m_active = 0; m_dir = 0; m_hi = 0; m_lo = 0; m_irq = 0;
        m_dtr = 0; m_dtf = 0; m_wait = 0; m_swal = 0; m_dlv = 0;
        m_data = 32'd0;
    endtask

    task automatic model_edge();
        logic [31:0] r;
        int code;
        bit clr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        code = !m_active ? 0 : (m_wait == 0 ? (m_dir ? 3 : 1) : (m_dir ? 2 : 4));
        case (bus_if.raddr_i)
            A_CTRL:  r = {29'd0, m_pol, m_ie, m_en};
            A_CFG:   r = {16'd0, 8'(m_dtf), 8'(m_dtr)};
            A_STAT:  r = {16'(m_dlv), 8'(m_swal), 4'd0, 3'(code), m_flag};
            default: r = 32'd0;
        endcase
        if (bus_if.rd_i) m_data = r;
        clr = bus_if.we_i && (bus_if.waddr_i == A_STAT) && bus_if.data_i[0];

        if (!m_en) begin
            m_active = 0; m_dir = 0; m_wait = 0; m_swal = 0; m_dlv = 0;
        end else if (m_flag) begin
            m_active = 0; m_dir = 0; m_wait = 0;
        end else if (!m_active) begin
            m_active = 1; m_dir = 0; m_wait = 0;
        end else if (m_pwm_q != m_dir) begin
            if (m_wait > 0) begin
                if (m_swal < 255) m_swal++;
                m_dir = m_pwm_q;
                m_wait = 0;
            end else begin
                m_dir = m_pwm_q;
                m_wait = m_dir ? m_dtr : m_dtf;
                if (m_wait == 0 && m_dir) m_dlv = (m_dlv + 1) % 65536;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0 && m_dir) m_dlv = (m_dlv + 1) % 65536;
        end
        m_hi = (m_active && m_dir && m_wait == 0) ^ m_pol;
        m_lo = (m_active && !m_dir && m_wait == 0) ^ m_pol;
        m_irq = BRK_ON && m_b2 && !m_flag && m_ie;
        m_flag = BRK_ON && (m_b2 || (m_flag && !clr));

        if (bus_if.we_i && bus_if.waddr_i == A_CTRL) begin
            m_en = bus_if.data_i[0]; m_ie = bus_if.data_i[1]; m_pol = bus_if.data_i[2];
        end
        if (bus_if.we_i && bus_if.waddr_i == A_CFG) begin
            m_dtr = int'(bus_if.data_i[7:0]); m_dtf = int'(bus_if.data_i[15:8]);
        end
        m_b2 = m_b1; m_b1 = brk_i; m_pwm_q = pwm_i;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("hi", {31'd0, pwm_hi_o}, {31'd0, m_hi});
        check_eq("lo", {31'd0, pwm_lo_o}, {31'd0, m_lo});
        check_eq("irq", {31'd0, irq_brk_o}, {31'd0, m_irq});
        check_eq("data_o", bus_if.data_o, m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        bus_if.we_i = 1'b1; bus_if.waddr_i = a; bus_if.data_i = v; bus_if.sel_i = 4'hF;
        tick();
        bus_if.we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        bus_if.rd_i = 1'b1; bus_if.raddr_i = a;
        tick();
        bus_if.rd_i = 1'b0;
        v = bus_if.data_o;
    endtask

    initial begin
        logic [31:0] d;
        int irq_cnt;
        bit saw_hi;
        int r;
        rst_n = 1'b0; pwm_i = 1'b0; brk_i = 1'b0;
        bus_if.we_i = 1'b0; bus_if.rd_i = 1'b0; bus_if.waddr_i = 8'd0;
        bus_if.raddr_i = 8'd0; bus_if.data_i = 32'd0; bus_if.sel_i = 4'd0;
        model_reset();
        idle(2);
        check_eq("rst_outs", {29'd0, pwm_hi_o, pwm_lo_o, irq_brk_o}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        wr(A_CFG, 32'hFFFF_ABCD);
        rd(A_CFG, d);
        check_eq("cfg_readback", d, 32'h0000_ABCD);
        rd(8'h10, d);
        check_eq("unmapped", d, 32'd0);

        // Basic dead time DTR=3, DTF=2
        wr(A_CFG, 32'h0000_0203);
        wr(A_CTRL, 32'd1);
        idle(3);
        pwm_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) check_eq("basic_lo_fall", {31'd0, pwm_lo_o}, 32'd0);
            if (k == 4) check_eq("basic_gap_r", {31'd0, pwm_hi_o}, 32'd0);
            if (k == 5) check_eq("basic_hi_rise", {31'd0, pwm_hi_o}, 32'd1);
        end
        idle(15);
        pwm_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) check_eq("basic_hi_fall", {31'd0, pwm_hi_o}, 32'd0);
            if (k == 3) check_eq("basic_gap_f", {31'd0, pwm_lo_o}, 32'd0);
            if (k == 4) check_eq("basic_lo_rise", {31'd0, pwm_lo_o}, 32'd1);
        end
        rd(A_STAT, d);
        check_eq("basic_dlv", {16'd0, d[31:16]}, 32'd1);

        // Glitch shorter than DTR=5
        wr(A_CFG, 32'd5);
        saw_hi = 1'b0;
        pwm_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) pwm_i = 1'b0;
            tick();
            saw_hi |= pwm_hi_o;
        end
        check_eq("glitch_no_hi", {31'd0, saw_hi}, 32'd0);
        check_eq("glitch_lo_back", {31'd0, pwm_lo_o}, 32'd1);
        rd(A_STAT, d);
        check_eq("glitch_swal", {24'd0, d[15:8]}, 32'd1);

        // Zero dead time with inverted polarity
        wr(A_CFG, 32'd0);
        wr(A_CTRL, 32'd5);
        idle(2);
        pwm_i = 1'b1;
        idle(2);
        check_eq("pol_hi_on", {30'd0, pwm_hi_o, pwm_lo_o}, 32'd1);
        pwm_i = 1'b0;
        idle(2);
        check_eq("pol_lo_on", {30'd0, pwm_hi_o, pwm_lo_o}, 32'd2);
        wr(A_CTRL, 32'd4);
        idle(1);
        check_eq("pol_off", {30'd0, pwm_hi_o, pwm_lo_o}, 32'd3);

        // Randomized pulses with live reconfiguration
        wr(A_CTRL, 32'd1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) pwm_i = ~pwm_i;
            r = int'($urandom_range(0, 99));
            if (r < 3)
                wr(A_CFG, {16'd0, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))});
            else if (r == 3)
                wr(A_CTRL, {29'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 7) != 0)});
            else if (r == 4)
                rd(A_STAT, d);
            else
                tick();
        end

        // Disable while in the rising gap
        wr(A_CTRL, 32'd1);
        wr(A_CFG, 32'd8);
        pwm_i = 1'b0;
        idle(12);
        pwm_i = 1'b1;
        idle(2);
        rd(A_STAT, d);
        check_eq("dis_in_dtr", {29'd0, d[3:1]}, 32'd2);
        wr(A_CTRL, 32'd0);
        idle(1);
        rd(A_STAT, d);
        check_eq("dis_state", {29'd0, d[3:1]}, 32'd0);
        check_eq("dis_counts", {d[31:16], d[15:8], 8'd0}, 32'd0);

        // Brake while HI
        wr(A_CTRL, 32'd3);
        wr(A_CFG, 32'd1);
        idle(5);
        check_eq("brk_pre_hi", {31'd0, pwm_hi_o}, 32'd1);
        brk_i = 1'b1;
        irq_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            irq_cnt += int'(irq_brk_o);
        end
        check_eq("brk_outs", {30'd0, pwm_hi_o, pwm_lo_o}, {30'd0, !BRK_ON, 1'b0});
        idle(4);
        irq_cnt += 0;
        check_eq("brk_irq_pulses", irq_cnt, BRK_ON ? 32'd1 : 32'd0);
        wr(A_STAT, 32'd1);
        rd(A_STAT, d);
        check_eq("brk_w1c_held", {31'd0, d[0]}, {31'd0, BRK_ON});
        pwm_i = 1'b0;
        brk_i = 1'b0;
        idle(4);
        wr(A_STAT, 32'd1);
        idle(3);
        rd(A_STAT, d);
        check_eq("brk_recover", {28'd0, d[3:0]}, 32'd2);

        // Asynchronous reset while HI
        wr(A_CTRL, 32'd1);
        wr(A_CFG, 32'd0);
        pwm_i = 1'b1;
        idle(4);
        check_eq("arst_pre_hi", {31'd0, pwm_hi_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_outs", {29'd0, pwm_hi_o, pwm_lo_o, irq_brk_o}, 32'd0);
        check_eq("arst_data", bus_if.data_o, 32'd0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/timer_deadtime.md
# timer_deadtime

Complementary PWM stage placed directly downstream of the system timer's compare output. It takes the single-ended compare signal (timer_cmpo_p), produces a high-side/low-side output pair with separately programmable rising and falling dead time, swallows input pulses shorter than the dead time, and forces both outputs inactive on a synchronised brake input. It is a memory-mapped peripheral on the same 32-bit system-peripheral bus as the timer.

## Interface
- No parameters; all timing is register-programmed.
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- waddr_i  input  8  write byte offset.
- data_i  input  32  write data.
- sel_i  input  4  byte enables; ignored, all writes are full-word.
- we_i  input  1  write strobe, one cycle per write.
- raddr_i  input  8  read byte offset.
- rd_i  input  1  read strobe.
- data_o  output  32  registered read data.
- pwm_i  input  1  compare output from the timer, synchronous to clk.
- brk_i  input  1  external brake request, active-high, asynchronous.
- pwm_hi_o  output  1  high-side drive.
- pwm_lo_o  output  1  low-side drive.
- irq_brk_o  output  1  brake interrupt, one-cycle pulse.

## Operation
- Registers:
  - DT_CTRL 0x00: [0] EN; [1] BRK_IE; [2] POL (invert both outputs); [31:3] read 0.
  - DT_CFG 0x04: [7:0] DTR, the rising dead time in cycles (both outputs off before HI); [15:8] DTF, the falling dead time (before LO); [31:16] read 0.
  - DT_STAT 0x08: [0] BRK flag, write 1 to clear; [3:1] state code; [15:8] swallowed-pulse count, 8-bit saturating, RO; [31:16] delivered-HI-pulse count, 16-bit wrapping, RO. All other writes to DT_STAT are ignored.
  - Unmapped reads return 0. data_o updates on the edge after rd_i=1 and holds otherwise.
- Input path:
  - pwm_i is registered once into pwm_q.
  - brk_i passes through a 2-flop synchroniser into brk_s.
- FSM states and codes: OFF=0, LO=1, DT_R=2, HI=3, DT_F=4. Raw outputs (hi,lo) are OFF (0,0), LO (0,1), DT_R (0,0), HI (1,0), DT_F (0,0).
  - OFF: go to LO when EN=1 and BRK flag=0.
  - LO: on pwm_q=1, go to DT_R and load cnt=DTR. If DTR=0, go directly to HI.
  - DT_R: if pwm_q=0, return to LO and increment the swallowed count. Otherwise, if cnt==1, go to HI; else decrement cnt.
  - HI: on pwm_q=0, go to DT_F with cnt=DTF. If DTF=0, go directly to LO.
  - DT_F: if pwm_q=1, return to HI and increment the swallowed count. If cnt==1, go to LO.
  - Every entry into HI from DT_R or LO increments the delivered count.
  - From any state, EN=0 or BRK flag=1 forces OFF on the next edge. This overrides all other transitions.
- Outputs: pwm_hi_o = hi^POL and pwm_lo_o = lo^POL. Both are registered and updated on the same edge as the state.
- Brake (see Configuration):
  - brk_s=1 sets the BRK flag.
  - irq_brk_o pulses for one cycle when the flag transitions 0→1 and BRK_IE=1.
  - The flag stays set while brk_s=1, even if written 1 to clear.
  - A write-1-to-clear in the same cycle as brk_s=1 leaves the flag set; set wins.
- While EN=0, both counters and cnt are held at 0.
- DTR or DTF written mid-dead-time takes effect at the next load; the running cnt is unaffected.

## Timing
- Reset values: all registers 0; state OFF; pwm_q, the brake synchroniser, cnt and data_o are 0; pwm_hi_o, pwm_lo_o and irq_brk_o are 0.
- Write-to-effect: a register write takes effect on the following edge. EN=1 written at edge W gives state LO after edge W+1.
- pwm_i sampled high at edge N: pwm_lo_o falls after edge N+1; pwm_hi_o rises after edge N+1+DTR. The falling direction is symmetric using DTF.
- Dead time is exactly DTR (or DTF) cycles with both outputs inactive. A value of 0 means no gap.
- brk_i assertion: outputs forced inactive within 4 edges (2 sync, 1 flag, 1 state). irq_brk_o is asserted in the same cycle the flag sets.
- HI and LO are never active in the same cycle, for any register sequence.

## Configuration
- DEADTIME_BRAKE_EN:
  - Defined: the brake path is as described above.
  - Undefined: brk_i is ignored (port retained); the BRK flag reads 0; irq_brk_o is tied 0; there are no synchroniser flops.

## Test plan
- Basic dead time: DTR=3, DTF=2, EN=1; pwm_i 0→1 held 20 cycles, then 0 → lo falls at N+1, hi rises at N+4; hi falls at M+1, lo rises at M+3; delivered count=1.
- Glitch: DTR=5; pwm_i high for 2 cycles → pwm_hi_o never asserts; lo returns high; swallowed count=1.
- Zero dead time and POL: DTR=DTF=0, POL=1; pwm_i toggles → outputs switch complementarily at N+1 with no gap; OFF outputs read (1,1).
- Brake: with HI active, brk_i=1 → both outputs inactive by edge +4; irq_brk_o is a single pulse with BRK_IE=1; W1C while brk_i=1 leaves flag=1; after release and W1C, state returns to LO.
- Disable mid-DT_R: EN=0 written → state OFF next edge; both counters read 0; async rst_n mid-HI resets all outputs to 0 immediately.
- Bus: read 0x10 → 0; DT_CFG write 0xFFFF_ABCD reads back 0x0000_ABCD.
